load_store_unit: RTL

//  MEM-stage initiator for the word-wide data RAM (1 write/clk, combinational read, no byte enables).

---
 rtl/load_store_unit_if.sv | 38 +++
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
//   Request/response bundle between the pipeline and the load/store unit.
//   Signals:
//     req_valid   request present
//     req_ready   unit can take a request this cycle
//     req_we      1 = store, 0 = load
//     req_funct3  RV32I funct3 of the access
//     req_addr    byte address
//     req_wdata   store data, right-aligned
//     rsp_valid   one-cycle completion pulse
//     rsp_error   completion carries an error
//     rsp_rdata   extended load data (0 for stores and errors)
//   Modports:
//     master  the requester (pipeline / testbench)
//     slave   the load/store unit
// ---------------------------------------------------------------------------
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_error;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_error, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_error, rsp_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   MEM-stage initiator for a word-wide data RAM with one write per clock and
//   a combinational read port. Loads extract and extend a byte/half/word from
//   the addressed word, SW writes the word directly, SB/SH do a two-cycle
//   read-modify-write. Misaligned, out-of-range and illegal-funct3 requests
//   complete with an error and never touch the RAM.
//   Ports:
//     clk                   rising-edge clock
//     rst_n                 synchronous active-low reset
//     bus                   request/response interface (slave side)
//     data_memory_address   RAM word index
//     data_memory_data_in   RAM write data
//     store                 RAM write strobe
//     load                  RAM read enable
//     data_memory_data_out  RAM read data, valid in the same cycle
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  load_store_unit_if.slave    bus,
  output logic [ADDR_W-1:0]   data_memory_address,
  output logic [31:0]         data_memory_data_in,
  output logic                store,
  output logic                load,
  input  logic [31:0]         data_memory_data_out
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       merge_q, merge_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_error_q, rsp_error_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic              accept;
  logic              legal;
  logic              misaligned;
  logic              out_of_range;
  logic              req_err;
  logic [ADDR_W-1:0] word_idx;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_ext;
  logic [31:0]       merge_word;

  assign bus.req_ready = (state_q == IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign word_idx      = bus.req_addr[ADDR_W+1:2];
  assign out_of_range  = (bus.req_addr[31:ADDR_W+2] != '0);

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  // Request classification. funct3[1:0] encodes the access size for every
  // legal encoding, so alignment only needs those two bits; for illegal
  // encodings the alignment result is irrelevant.
  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    case (bus.req_funct3)
      3'd0, 3'd1, 3'd2: legal = 1'b1;
      3'd4, 3'd5:       legal = !bus.req_we;
      default:          legal = 1'b0;
    endcase
    case (bus.req_funct3[1:0])
      2'd1:    misaligned = bus.req_addr[0];
      2'd2:    misaligned = (bus.req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    req_err = !legal || misaligned || out_of_range;
  end

  // Lane selection from the RAM word, then sign/zero extension for loads and
  // lane replacement for SB/SH. The merged word is captured on the accept
  // edge and written back in the following cycle.
  always_comb begin
    byte_sel = 8'h00;
    case (bus.req_addr[1:0])
      2'd0: byte_sel = data_memory_data_out[7:0];
      2'd1: byte_sel = data_memory_data_out[15:8];
      2'd2: byte_sel = data_memory_data_out[23:16];
      2'd3: byte_sel = data_memory_data_out[31:24];
    endcase
    half_sel = bus.req_addr[1] ? data_memory_data_out[31:16] : data_memory_data_out[15:0];

    case (bus.req_funct3)
      3'd0:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_ext = {24'h000000, byte_sel};
      3'd5:    load_ext = {16'h0000, half_sel};
      default: load_ext = data_memory_data_out;
    endcase

    merge_word = data_memory_data_out;
    if (bus.req_funct3[1:0] == 2'd0) begin
      case (bus.req_addr[1:0])
        2'd0: merge_word[7:0]   = bus.req_wdata[7:0];
        2'd1: merge_word[15:8]  = bus.req_wdata[7:0];
        2'd2: merge_word[23:16] = bus.req_wdata[7:0];
        2'd3: merge_word[31:24] = bus.req_wdata[7:0];
      endcase
    end else if (bus.req_addr[1]) begin
      merge_word[31:16] = bus.req_wdata[15:0];
    end else begin
      merge_word[15:0] = bus.req_wdata[15:0];
    end
  end

  // Next-state and RAM port drive. The RAM port is idle (all zero) unless a
  // legal request is accepted in IDLE or the RMW write-back is in progress.
  // The write-back is gated by rst_n so a reset during WRITE drops the store
  // rather than committing a half-finished transaction.
  always_comb begin
    state_d             = state_q;
    addr_d              = addr_q;
    merge_d             = merge_q;
    rsp_valid_d         = 1'b0;
    rsp_error_d         = 1'b0;
    rsp_rdata_d         = 32'h0;
    load                = 1'b0;
    store               = 1'b0;
    data_memory_address = '0;
    data_memory_data_in = 32'h0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_valid_d = 1'b1;
          if (req_err) begin
            rsp_error_d = 1'b1;
          end else if (!bus.req_we) begin
            load                = 1'b1;
            data_memory_address = word_idx;
            rsp_rdata_d         = load_ext;
          end else if (bus.req_funct3 == 3'd2) begin
            store               = 1'b1;
            data_memory_address = word_idx;
            data_memory_data_in = bus.req_wdata;
          end else begin
            load                = 1'b1;
            data_memory_address = word_idx;
            addr_d              = word_idx;
            merge_d             = merge_word;
            rsp_valid_d         = 1'b0;
            state_d             = WRITE;
          end
        end
      end
      WRITE: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        if (rst_n) begin
          store               = 1'b1;
          data_memory_address = addr_q;
          data_memory_data_in = merge_q;
        end
      end
    endcase
  end

  // State and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      merge_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      merge_q     <= merge_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule
